// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, iter_alu FSM states and step kinds.
// Build option: ITER_ALU_MUL_EN compiles in the MUL state and datapath.
package cpu_pkg;

    // 4-bit opcode; values 0..7 keep the original 3-bit encodings.
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6,
        OP_SLT = 4'd7,
        OP_SRA = 4'd8,
        OP_MUL = 4'd9
    } alu_op_t;

    // Control states of the iterative ALU.
`ifdef ITER_ALU_MUL_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DONE  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_MUL   = 2'd3
    } iter_alu_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DONE  = 2'd1,
        ST_SHIFT = 2'd2
    } iter_alu_state_t;
`endif

    // Per-step operation performed by the shift/multiply engine.
    localparam logic [1:0] STEP_SLL = 2'd0;
    localparam logic [1:0] STEP_SRL = 2'd1;
    localparam logic [1:0] STEP_SRA = 2'd2;
    localparam logic [1:0] STEP_MUL = 2'd3;

endpackage

// File: rtl/iter_alu_shift_mul.sv
// Multi-cycle engine for iter_alu: one-bit-per-cycle shifter and, when
// ITER_ALU_MUL_EN is defined, a shift-add multiplier sharing the counter
// and working register (the working register doubles as the accumulator).
module iter_alu_shift_mul
    import cpu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         kind_in,
    input  logic [XLEN-1:0]    a,
`ifdef ITER_ALU_MUL_EN
    input  logic [XLEN-1:0]    b,
`endif
    input  logic [SHAMT_W-1:0] shamt,
    output logic               last,
    output logic [XLEN-1:0]    next_value
);

    // One extra bit so the counter can hold XLEN for a multiply.
    localparam int CNT_W = SHAMT_W + 1;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       kind;
    logic [XLEN-1:0]  work;
`ifdef ITER_ALU_MUL_EN
    logic [XLEN-1:0]  mcand;
    logic [XLEN-1:0]  mplier;
`endif

    // The step taking the counter from 1 to 0 is the final one.
    assign last = (cnt == CNT_W'(1));

    // Value the working register takes on the next step.
    always_comb begin
        next_value = work;
        case (kind)
            STEP_SLL: next_value = {work[XLEN-2:0], 1'b0};
            STEP_SRL: next_value = {1'b0, work[XLEN-1:1]};
            STEP_SRA: next_value = {work[XLEN-1], work[XLEN-1:1]};
`ifdef ITER_ALU_MUL_EN
            STEP_MUL: next_value = mplier[0] ? (work + mcand) : work;
`endif
            default:  next_value = work;
        endcase
    end

    // Step counter and operation kind; a nonzero count means a step runs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            kind <= STEP_SLL;
        end else if (start) begin
            kind <= kind_in;
`ifdef ITER_ALU_MUL_EN
            if (kind_in == STEP_MUL)
                cnt <= CNT_W'(XLEN);
            else
                cnt <= {1'b0, shamt};
`else
            cnt <= {1'b0, shamt};
`endif
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Datapath registers; only meaningful while the counter is running.
    always_ff @(posedge clk) begin
        if (start) begin
`ifdef ITER_ALU_MUL_EN
            work   <= (kind_in == STEP_MUL) ? '0 : a;
            mcand  <= a;
            mplier <= b;
`else
            work   <= a;
`endif
        end else if (cnt != '0) begin
            work   <= next_value;
`ifdef ITER_ALU_MUL_EN
            mcand  <= {mcand[XLEN-2:0], 1'b0};
            mplier <= {1'b0, mplier[XLEN-1:1]};
`endif
        end
    end

endmodule

// File: rtl/iter_alu.sv
// Handshaked, multi-cycle execute ALU. Single-cycle ops finish on the accept
// edge; shifts and (with ITER_ALU_MUL_EN defined) MUL run in the
// iter_alu_shift_mul engine. The result is held until out_ready takes it.
module iter_alu
    import cpu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      alu_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    iter_alu_state_t    state;
    iter_alu_state_t    iter_state;
    logic               accept;
    logic               start_iter;
    logic [1:0]         kind;
    logic [SHAMT_W-1:0] shamt;
    logic               last;
    logic [XLEN-1:0]    next_value;

    // Result of every op that completes on the accept edge. Shifts only land
    // here with a zero shift amount, so they pass operand A through; unknown
    // opcodes (and MUL when it is not built) give zero.
    function automatic logic [XLEN-1:0] alu_single(input logic [XLEN-1:0] op_a,
                                                   input logic [XLEN-1:0] op_b,
                                                   input logic [3:0]      op);
        logic [XLEN-1:0] r;
        case (op)
            OP_ADD:  r = op_a + op_b;
            OP_SUB:  r = op_a - op_b;
            OP_AND:  r = op_a & op_b;
            OP_OR:   r = op_a | op_b;
            OP_XOR:  r = op_a ^ op_b;
            OP_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLL,
            OP_SRL,
            OP_SRA:  r = op_a;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign shamt     = b[SHAMT_W-1:0];
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
`ifdef ITER_ALU_MUL_EN
    assign busy      = (state == ST_SHIFT) || (state == ST_MUL);
`else
    assign busy      = (state == ST_SHIFT);
`endif

    // Decide whether the presented op needs the multi-cycle engine.
    always_comb begin
        start_iter = 1'b0;
        kind       = STEP_SLL;
        iter_state = ST_SHIFT;
        case (alu_op)
            OP_SLL: begin
                kind       = STEP_SLL;
                start_iter = |shamt;
            end
            OP_SRL: begin
                kind       = STEP_SRL;
                start_iter = |shamt;
            end
            OP_SRA: begin
                kind       = STEP_SRA;
                start_iter = |shamt;
            end
`ifdef ITER_ALU_MUL_EN
            OP_MUL: begin
                kind       = STEP_MUL;
                start_iter = 1'b1;
                iter_state = ST_MUL;
            end
`endif
            default: ;
        endcase
    end

    iter_alu_shift_mul #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_engine (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (accept && start_iter),
        .kind_in    (kind),
        .a          (a),
`ifdef ITER_ALU_MUL_EN
        .b          (b),
`endif
        .shamt      (shamt),
        .last       (last),
        .next_value (next_value)
    );

    // Control FSM: IDLE -> (SHIFT|MUL ->) DONE -> IDLE on output handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (accept) state <= start_iter ? iter_state : ST_DONE;
                ST_SHIFT: if (last) state <= ST_DONE;
`ifdef ITER_ALU_MUL_EN
                ST_MUL:   if (last) state <= ST_DONE;
`endif
                ST_DONE:  if (out_ready) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Result register: written only when an op completes, otherwise held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result <= '0;
        end else if (accept && !start_iter) begin
            result <= alu_single(a, b, alu_op);
        end else if (busy && last) begin
            result <= next_value;
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu (XLEN=32). Directed cases, a randomized
// sweep against an arithmetic reference model, backpressure and reset abort.
// Honours ITER_ALU_MUL_EN the same way as the design.
module tb_iter_alu;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] a = '0;
    logic [XLEN-1:0] b = '0;
    logic [3:0]      alu_op = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] result;
    logic            busy;

    int checks = 0;
    int errors = 0;

    iter_alu #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Expected result straight from the arithmetic definition of each op.
    function automatic logic [31:0] ref_result(input logic [3:0] op,
                                               input logic [31:0] x,
                                               input logic [31:0] y);
        int sh;
        sh = int'(y % 32);
        case (op)
            4'd0: return x + y;
            4'd1: return x - y;
            4'd2: return x & y;
            4'd3: return x | y;
            4'd4: return x ^ y;
            4'd5: return x << sh;
            4'd6: return x >> sh;
            4'd7: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd8: return 32'($signed(x) >>> sh);
`ifdef ITER_ALU_MUL_EN
            4'd9: return 32'(64'(x) * 64'(y));
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Expected edges between accept and out_valid.
    function automatic int ref_latency(input logic [3:0] op, input logic [31:0] y);
        case (op)
            4'd5, 4'd6, 4'd8: return int'(y % 32);
`ifdef ITER_ALU_MUL_EN
            4'd9: return 32;
`endif
            default: return 0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Issue one op, measure latency and busy cycles, optionally hold off the
    // consumer for 'hold' cycles, and optionally pulse in_valid while busy.
    task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          input int hold, input bit poke, input string tag);
        logic [31:0] er;
        int el, lat, bc, n;
        er = ref_result(op, x, y);
        el = ref_latency(op, y);
        out_ready = (hold == 0);
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, " in_ready_before"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; a = x; b = y; alu_op = op;
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; alu_op = 4'($urandom);
        lat = 0; bc = 0;
        while (!out_valid && lat < 100) begin
            if (busy) begin
                bc++;
                in_valid = poke;
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(el));
        check({tag, " result"}, result, er);
        check({tag, " busy_cycles"}, 32'(bc), 32'(el));
        check({tag, " in_ready_done"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold_result"}, result, er);
            check({tag, " hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " in_ready_after"}, 32'(in_ready), 32'd1);
        check({tag, " out_valid_after"}, 32'(out_valid), 32'd0);
        check({tag, " result_kept"}, result, er);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] rx, ry;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst result", result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed cases
        run_op(4'd0, 32'd4, 32'd2, 0, 1'b0, "add");
        run_op(4'd1, 32'd4, 32'd2, 0, 1'b0, "sub");
        run_op(4'd7, 32'hFFFF_FFFF, 32'd2, 0, 1'b0, "slt_neg");
        run_op(4'd7, 32'd5, 32'hFFFF_FFFF, 0, 1'b0, "slt_pos");
        run_op(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 1'b0, "and");
        run_op(4'd3, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 1'b0, "or");
        run_op(4'd4, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 1'b0, "xor");
        run_op(4'd5, 32'd4, 32'd2, 0, 1'b0, "sll");
        run_op(4'd5, 32'd4, 32'd0, 0, 1'b0, "sll_zero");
        run_op(4'd8, 32'h8000_0000, 32'd3, 0, 1'b0, "sra");
        run_op(4'd6, 32'h8000_0000, 32'd3, 0, 1'b1, "srl_poke");
        run_op(4'd5, 32'h0000_0001, 32'd31, 0, 1'b0, "sll_max");
        run_op(4'd9, 32'd3005, 32'd3, 0, 1'b0, "mul");
        run_op(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, "mul_ones");
        run_op(4'd12, 32'd7, 32'd9, 0, 1'b0, "unknown");
        run_op(4'd0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, "add_wrap");
        run_op(4'd0, 32'd100, 32'd23, 5, 1'b0, "backpressure");

        // Randomized sweep over all opcodes
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            rx  = $urandom;
            ry  = $urandom;
            run_op(rop, rx, ry, int'($urandom_range(0, 2)), 1'($urandom), "rand");
        end

        // Reset abort mid-operation, with a nonzero result already held
        run_op(4'd0, 32'd7, 32'd8, 0, 1'b0, "pre_reset");
        @(negedge clk);
        in_valid = 1'b1; a = 32'd3005; b = 32'd31;
`ifdef ITER_ALU_MUL_EN
        alu_op = 4'd9;
`else
        alu_op = 4'd5;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("abort busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort result", result, 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op(4'd0, 32'd1, 32'd1, 0, 1'b0, "post_reset_add");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iter_alu.md
# iter_alu

Parametrised, handshaked successor to the CPU's combinational `alu`, used as the execute unit of the upcoming multi-cycle core.
- Accepts one operation at a time over a valid/ready input channel.
- Logic ops, ADD/SUB and SLT complete in one cycle; shifts run one bit per cycle; the optional MUL is a shift-add multiplier.
- The result is held on a valid/ready output channel until it is taken.

## Interface
- `XLEN`, default 32: operand/result width, ≥ 8, power of two.
- `SHAMT_W`, default `$clog2(XLEN)`: shift-amount width, derived and not to be overridden.
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset. One clock; the asynchronous active-low polarity is fixed.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `a`  in  XLEN  operand A.
- `b`  in  XLEN  operand B. Shifts use `b[SHAMT_W-1:0]`.
- `alu_op`  in  4  `alu_op_t` opcode.
- `out_valid`  out  1  result available; high only in DONE.
- `out_ready`  in  1  consumer takes result.
- `result`  out  XLEN  registered result.
- `busy`  out  1  high in SHIFT or MUL.

## Operation
- States and transitions:
  - IDLE → DONE on accept of ADD, SUB, AND, OR, XOR, SLT, an unknown op, or a shift with shamt 0.
  - IDLE → SHIFT on accept of SLL/SRL/SRA with shamt > 0.
  - IDLE → MUL on accept of MUL.
  - SHIFT / MUL → DONE on the final step.
  - DONE → IDLE on `out_valid && out_ready`.
- Accept happens on an edge where `in_valid && in_ready`. Operands are captured at that edge, so the source may change them afterwards.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT is signed and yields 1 or 0.
  - SLL/SRL are logical shifts; SRA replicates `a[XLEN-1]`.
  - An unknown opcode yields 0.
- SHIFT: a working register is loaded with `a` and a counter with shamt. Each edge shifts by one bit and decrements the counter; the edge that takes the counter 1→0 enters DONE.
- MUL: multiplicand = `a`, multiplier = `b`, accumulator = 0, counter = XLEN. Each edge:
  - add the multiplicand to the accumulator if multiplier bit 0 is set;
  - shift the multiplicand left and the multiplier right;
  - decrement the counter.
  - `result` = low XLEN bits of the product (signedness irrelevant).
- `result` keeps its last value after the output handshake until the next completion overwrites it.
- No accept is possible in the cycle DONE exits. `in_ready` rises the cycle after the output handshake.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `result`=0, state IDLE, counters 0.
- Latency L = edges after the accept edge before `out_valid` is seen high:
  - single-cycle ops: L=0, so `out_valid` is high in the cycle right after accept;
  - shifts: L=shamt;
  - MUL: L=XLEN.
- Throughput with `out_ready` held at 1: one op per L+2 cycles.
- Backpressure: DONE holds indefinitely with `result` stable.
- Reset asserted mid-operation aborts immediately to reset values. No partial result is ever presented.
- `in_valid` while `in_ready`=0 is ignored, not queued.

## Configuration
- `ITER_ALU_MUL_EN` defined: the MUL state and datapath are compiled in as described above.
- `ITER_ALU_MUL_EN` undefined:
  - the MUL state and adder/shift registers are absent;
  - opcode MUL is treated as unknown: one cycle, result 0;
  - `busy` is never high for it.

## Structure
- `cpu_pkg` holds the shared definitions:
  - `alu_op_t`, widened to 4 bits: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SLT=7, SRA=8, MUL=9. The existing 3-bit encodings are unchanged in value.
  - the state enum `iter_alu_state_t`.
- Sub-module `iter_alu_shift_mul` owns the counter, the working/accumulator registers and step logic. The top handles the handshake and FSM.

## Test plan
- ADD a=4 b=2: accept, then `out_valid` high next cycle with `result`=6. SUB gives 2; SLT a=-1 b=2 gives 1.
- SLL a=4 b=2 → result 16, `out_valid` 2 edges after accept, `busy` high for exactly 2 cycles. SLL with b=0 behaves as single-cycle and returns 4.
- SRA a=0x80000000 b=3 → 0xF0000000 after 3 edges. SRL with the same operands → 0x10000000.
- MUL (macro on) a=3005 b=3 → 9015 after 32 edges; a=0xFFFFFFFF b=0xFFFFFFFF → 1. Macro off: MUL → 0 next cycle.
- Backpressure: `out_ready`=0 for 5 cycles after ADD completes → `result`, `out_valid` stable and `in_ready`=0. Then `out_ready`=1 → `in_ready` high the following cycle. `in_valid` pulses while busy are ignored.
- Assert `reset_n` low at step 10 of a MUL → `in_ready`=1, `out_valid`=0, `result`=0 immediately. After release, a fresh ADD 1+1 returns 2.
